// File: rtl/sram_a_loader_pkg.sv
// Shared LeNet constants and types used by the SRAM A loader and its address map.
package sram_a_loader_pkg;

  localparam int IMG_W      = 28;
  localparam int IMG_H      = 28;
  localparam int NUM_BANK_A = 9;
  localparam int ADDR_W     = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_e;

  // Words per bank row: each bank word covers a 2x2 pixel block, banks tile 3 blocks wide.
  function automatic int words_per_row(input int img_w);
    return (img_w + 5) / 6;
  endfunction

endpackage

// File: rtl/sram_a_addr_map.sv
// Pixel (r,c) to A-bank location: 2x2 blocks become byte lanes, blocks tile over a 3x3 bank grid.
module sram_a_addr_map
  import sram_a_loader_pkg::*;
#(
  parameter int IMG_W = sram_a_loader_pkg::IMG_W,
  parameter int R_W   = 5,
  parameter int C_W   = 5
) (
  input  logic [R_W-1:0]    r,
  input  logic [C_W-1:0]    c,
  output logic [3:0]        bank,
  output logic [ADDR_W-1:0] addr,
  output logic [1:0]        lane
);

  logic [15:0] br;
  logic [15:0] bc;

  always_comb begin
    br   = 16'(r >> 1);
    bc   = 16'(c >> 1);
    bank = 4'((br % 16'd3) * 16'd3 + (bc % 16'd3));
    addr = ADDR_W'((br / 16'd3) * 16'(words_per_row(IMG_W)) + (bc / 16'd3));
    lane = {r[0], c[0]};
  end

endmodule

// File: rtl/sram_a_loader.sv
// Streams one raster-order image from the host into the nine A SRAM banks,
// one byte write per accepted pixel, presented one cycle after acceptance.
module sram_a_loader
  import sram_a_loader_pkg::*;
#(
  parameter int IMG_W = sram_a_loader_pkg::IMG_W,
  parameter int IMG_H = sram_a_loader_pkg::IMG_H
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  load_start,
  input  logic                  img_valid,
  input  logic [7:0]            img_data,
  output logic                  img_ready,
  output logic                  busy,
  output logic                  load_done,
  output logic [NUM_BANK_A-1:0] sram_write_enable_a,
  output logic [3:0]            sram_bytemask_a,
  output logic [ADDR_W-1:0]     sram_waddr_a,
  output logic [31:0]           sram_wdata_a
);

  localparam int R_W = $clog2(IMG_H);
  localparam int C_W = $clog2(IMG_W);

  load_state_e           state_q, state_d;
  logic [R_W-1:0]        r_q, r_d;
  logic [C_W-1:0]        c_q, c_d;
  logic                  img_ready_q, img_ready_d;
  logic                  busy_q, busy_d;
  logic                  load_done_q, load_done_d;
  logic [NUM_BANK_A-1:0] we_q, we_d;
  logic [3:0]            mask_q, mask_d;
  logic [ADDR_W-1:0]     waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;

  logic                  accept_s;
  logic                  last_col_s;
  logic                  last_pix_s;
  logic [3:0]            bank_s;
  logic [ADDR_W-1:0]     addr_s;
  logic [1:0]            lane_s;

  sram_a_addr_map #(
    .IMG_W (IMG_W),
    .R_W   (R_W),
    .C_W   (C_W)
  ) u_addr_map (
    .r    (r_q),
    .c    (c_q),
    .bank (bank_s),
    .addr (addr_s),
    .lane (lane_s)
  );

  // Next-state, counter and write-port computation; non-write cycles idle the SRAM bus.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    load_done_d = 1'b0;
    we_d        = {NUM_BANK_A{1'b1}};
    mask_d      = 4'hF;
    waddr_d     = {ADDR_W{1'b0}};
    wdata_d     = 32'd0;
    accept_s    = (state_q == LOAD) && img_valid;
    last_col_s  = (c_q == C_W'(IMG_W - 1));
    last_pix_s  = last_col_s && (r_q == R_W'(IMG_H - 1));

    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = LOAD;
          r_d     = {R_W{1'b0}};
          c_d     = {C_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (accept_s) begin
          we_d    = ~(NUM_BANK_A'(1) << bank_s);
          mask_d  = ~(4'b0001 << lane_s);
          waddr_d = addr_s;
          wdata_d = 32'(img_data) << {lane_s, 3'b000};
          if (last_col_s) begin
            c_d = {C_W{1'b0}};
            r_d = r_q + R_W'(1);
          end else begin
            c_d = c_q + C_W'(1);
          end
          if (last_pix_s) begin
            state_d = DONE;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = LOAD;
        end
      end
      DONE: begin
        state_d     = IDLE;
        load_done_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    img_ready_d = (state_d == LOAD);
    busy_d      = (state_d != IDLE);
  end

  // State, counters and every host/SRAM-facing output are registered here.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= IDLE;
      r_q         <= {R_W{1'b0}};
      c_q         <= {C_W{1'b0}};
      img_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      we_q        <= {NUM_BANK_A{1'b1}};
      mask_q      <= 4'hF;
      waddr_q     <= {ADDR_W{1'b0}};
      wdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      c_q         <= c_d;
      img_ready_q <= img_ready_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
      we_q        <= we_d;
      mask_q      <= mask_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign img_ready           = img_ready_q;
  assign busy                = busy_q;
  assign load_done           = load_done_q;
  assign sram_write_enable_a = we_q;
  assign sram_bytemask_a     = mask_q;
  assign sram_waddr_a        = waddr_q;
  assign sram_wdata_a        = wdata_q;

endmodule

// File: tb/tb_sram_a_loader.sv
// Directed bench for sram_a_loader: full image streams, gaps, mid-load reset and stray load_start.
module tb_sram_a_loader;

  logic        clk = 1'b0;
  logic        srst;
  logic        load_start;
  logic        img_valid;
  logic [7:0]  img_data;
  logic        img_ready;
  logic        busy;
  logic        load_done;
  logic [8:0]  sram_write_enable_a;
  logic [3:0]  sram_bytemask_a;
  logic [9:0]  sram_waddr_a;
  logic [31:0] sram_wdata_a;

  int total = 0;
  int bad   = 0;
  int wr_cnt;
  int ld_cnt;
  int dups;
  bit seen [9][1024][4];

  always #5 clk = ~clk;

  sram_a_loader #(
    .IMG_W (28),
    .IMG_H (28)
  ) dut (
    .clk                 (clk),
    .srst                (srst),
    .load_start          (load_start),
    .img_valid           (img_valid),
    .img_data            (img_data),
    .img_ready           (img_ready),
    .busy                (busy),
    .load_done           (load_done),
    .sram_write_enable_a (sram_write_enable_a),
    .sram_bytemask_a     (sram_bytemask_a),
    .sram_waddr_a        (sram_waddr_a),
    .sram_wdata_a        (sram_wdata_a)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock; observe just after the edge and keep running write / done counts.
  task automatic tick();
    @(posedge clk);
    #1;
    if (sram_write_enable_a !== 9'h1FF) wr_cnt++;
    if (load_done === 1'b1) ld_cnt++;
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    if (r == 0 && c == 0) return 8'h11;
    if (r == 0 && c == 1) return 8'h22;
    if (r == 2 && c == 6) return 8'h5A;
    if (r == 27 && c == 27) return 8'hC3;
    return 8'((r * 7 + c * 13 + 1) & 255);
  endfunction

  // Expected {enables, mask, addr, wdata}; 28-wide image gives 5 words per bank row.
  function automatic logic [63:0] exp_wr(input int r, input int c, input logic [7:0] d);
    int bank;
    int addr;
    int lane;
    logic [8:0]  en;
    logic [3:0]  mk;
    logic [31:0] wd;
    bank = ((r / 2) % 3) * 3 + ((c / 2) % 3);
    addr = ((r / 2) / 3) * 5 + ((c / 2) / 3);
    lane = (r % 2) * 2 + (c % 2);
    en   = ~(9'h001 << bank);
    mk   = ~(4'h1 << lane);
    wd   = {24'd0, d} << (8 * lane);
    return {9'd0, en, mk, 10'(addr), wd};
  endfunction

  function automatic logic [63:0] obs_wr();
    return {9'd0, sram_write_enable_a, sram_bytemask_a, sram_waddr_a, sram_wdata_a};
  endfunction

  task automatic note_seen();
    int ob = -1;
    int ol = -1;
    for (int b = 0; b < 9; b++) if (sram_write_enable_a[b] == 1'b0) ob = b;
    for (int k = 0; k < 4; k++) if (sram_bytemask_a[k] == 1'b0) ol = k;
    if (ob >= 0 && ol >= 0) begin
      if (seen[ob][sram_waddr_a][ol]) dups++;
      seen[ob][sram_waddr_a][ol] = 1'b1;
    end
  endtask

  task automatic run_load(input int npix, input bit gaps, input int pulse_idx);
    int r;
    int c;
    wr_cnt = 0;
    ld_cnt = 0;
    dups   = 0;
    for (int b = 0; b < 9; b++)
      for (int a = 0; a < 1024; a++)
        for (int k = 0; k < 4; k++) seen[b][a][k] = 1'b0;

    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check_val("enter_load", {62'd0, busy, img_ready}, 64'd3);

    for (int idx = 0; idx < npix; idx++) begin
      r = idx / 28;
      c = idx % 28;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          img_valid = 1'b0;
          tick();
          check_val("gap_nowr", {55'd0, sram_write_enable_a}, 64'h1FF);
        end
      end
      img_valid  = 1'b1;
      img_data   = pix(r, c);
      load_start = (idx == pulse_idx);
      tick();
      load_start = 1'b0;
      check_val("wr", obs_wr(), exp_wr(r, c, pix(r, c)));
      note_seen();
      if (r == 0 && c == 0)   check_val("p00",   obs_wr(), {9'd0, 9'h1FE, 4'hE, 10'd0, 32'h0000_0011});
      if (r == 0 && c == 1)   check_val("p01",   obs_wr(), {9'd0, 9'h1FE, 4'hD, 10'd0, 32'h0000_2200});
      if (r == 2 && c == 6)   check_val("p26",   obs_wr(), {9'd0, 9'h1F7, 4'hE, 10'd1, 32'h0000_005A});
      if (r == 27 && c == 27) check_val("p2727", obs_wr(), {9'd0, 9'h1EF, 4'h7, 10'd24, 32'hC300_0000});
    end

    if (npix == 784) begin
      // img_valid stays high through DONE and IDLE to show it is ignored there.
      check_val("done_state", {61'd0, img_ready, busy, load_done}, 64'b010);
      tick();
      check_val("done_pulse", {52'd0, img_ready, busy, load_done, sram_write_enable_a},
                {52'd0, 3'b001, 9'h1FF});
      img_valid = 1'b0;
      tick();
      check_val("done_clear", {63'd0, load_done}, 64'd0);
      tick();
      check_val("ld_once", 64'(ld_cnt), 64'd1);
      check_val("wr_count", 64'(wr_cnt), 64'd784);
      check_val("no_dup", 64'(dups), 64'd0);
    end
  endtask

  initial begin
    srst       = 1'b1;
    load_start = 1'b0;
    img_valid  = 1'b0;
    img_data   = 8'h00;
    wr_cnt     = 0;
    ld_cnt     = 0;
    dups       = 0;
    tick();
    tick();
    check_val("reset_out",
              {img_ready, busy, load_done, sram_write_enable_a, sram_bytemask_a, sram_waddr_a, sram_wdata_a},
              {6'd0, 3'b000, 9'h1FF, 4'hF, 10'd0, 32'd0});
    srst = 1'b0;

    img_valid = 1'b1;
    img_data  = 8'hAA;
    tick();
    check_val("idle_ignore", {54'd0, img_ready, sram_write_enable_a}, {54'd0, 1'b0, 9'h1FF});
    img_valid = 1'b0;
    tick();

    run_load(784, 1'b0, 300);
    run_load(784, 1'b1, -1);

    run_load(100, 1'b0, -1);
    srst = 1'b1;
    tick();
    check_val("srst_mid", {53'd0, img_ready, busy, sram_write_enable_a}, {53'd0, 2'b00, 9'h1FF});
    srst      = 1'b0;
    img_valid = 1'b0;
    tick();
    check_val("post_srst", {52'd0, img_ready, busy, load_done, sram_write_enable_a},
              {52'd0, 3'b000, 9'h1FF});

    run_load(784, 1'b1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
